// File: rtl/pawn_eval_pkg.sv
// Shared constants, FSM state type and table-access helpers for the pawn evaluation stage.
package pawn_eval_pkg;

  localparam int NUM_SQ     = 64;
  localparam int PST_W      = 6;
  localparam int PST_FLAT_W = 384;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } state_t;

  // Flip the rank (bits 5:3) and keep the file (bits 2:0).
  function automatic logic [5:0] mirror_sq(input logic [5:0] s);
    return s ^ 6'd56;
  endfunction

  function automatic logic signed [PST_W-1:0] pst_entry(input logic [PST_FLAT_W-1:0] flat,
                                                        input logic [5:0] s);
    return flat[int'(s) * PST_W +: PST_W];
  endfunction

endpackage

// File: rtl/pst_slice_adder.sv
// Combinational partial sum of SQ_PER_CYCLE masked, sign-extended table entries for one side.
module pst_slice_adder
  import pawn_eval_pkg::*;
#(
  parameter int SQ_PER_CYCLE = 8,
  parameter int SCORE_W      = 12
) (
  input  logic [SQ_PER_CYCLE-1:0] mask,
  input  logic [5:0]              base,
  input  logic [PST_FLAT_W-1:0]   pst_flat,
  input  logic                    mirror,
  output logic [SCORE_W-1:0]      sum
);

  logic [SCORE_W-1:0] term [SQ_PER_CYCLE];

  for (genvar gi = 0; gi < SQ_PER_CYCLE; gi++) begin : g_sq
    logic [5:0]       sq;
    logic [PST_W-1:0] entry;
    assign sq    = base + 6'(gi);
    assign entry = pst_entry(pst_flat, mirror ? mirror_sq(sq) : sq);
    assign term[gi] = mask[gi] ? {{(SCORE_W-PST_W){entry[PST_W-1]}}, entry} : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < SQ_PER_CYCLE; i++) begin
      sum = sum + term[i];
    end
  end

endmodule

// File: rtl/pawn_pst_accumulator.sv
// Sequential pawn piece-square scorer: white minus rank-mirrored black, SQ_PER_CYCLE squares per clock.
// Optional popcount outputs white_count/black_count are built when PAWN_PST_COUNT_EN is defined.
module pawn_pst_accumulator
  import pawn_eval_pkg::*;
#(
  parameter int SQ_PER_CYCLE = 8,
  parameter int SCORE_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_SQ-1:0]     white_pawns,
  input  logic [NUM_SQ-1:0]     black_pawns,
  input  logic [PST_FLAT_W-1:0] pst_flat,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [SCORE_W-1:0]    score
`ifdef PAWN_PST_COUNT_EN
  ,
  output logic [6:0]            white_count,
  output logic [6:0]            black_count
`endif
);

  state_t                   state_reg, state_next;
  logic [NUM_SQ-1:0]        white_reg, black_reg;
  logic [6:0]               cnt_reg;
  logic [SCORE_W-1:0]       acc_reg, score_reg;
  logic                     done_reg;
  logic [SQ_PER_CYCLE-1:0]  white_mask, black_mask;
  logic [SCORE_W-1:0]       white_sum, black_sum, acc_next;
  logic                     last_slice, load_en, scan_en, finish_en;

  assign white_mask = white_reg[cnt_reg[5:0] +: SQ_PER_CYCLE];
  assign black_mask = black_reg[cnt_reg[5:0] +: SQ_PER_CYCLE];
  assign last_slice = (cnt_reg + 7'(SQ_PER_CYCLE)) >= 7'(NUM_SQ);
  assign acc_next   = acc_reg + white_sum - black_sum;

  pst_slice_adder #(
    .SQ_PER_CYCLE (SQ_PER_CYCLE),
    .SCORE_W      (SCORE_W)
  ) u_white_adder (
    .mask     (white_mask),
    .base     (cnt_reg[5:0]),
    .pst_flat (pst_flat),
    .mirror   (1'b0),
    .sum      (white_sum)
  );

  pst_slice_adder #(
    .SQ_PER_CYCLE (SQ_PER_CYCLE),
    .SCORE_W      (SCORE_W)
  ) u_black_adder (
    .mask     (black_mask),
    .base     (cnt_reg[5:0]),
    .pst_flat (pst_flat),
    .mirror   (1'b1),
    .sum      (black_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    scan_en    = 1'b0;
    finish_en  = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        load_en    = 1'b1;
        state_next = SCAN;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (last_slice) begin
          finish_en  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      white_reg <= '0;
      black_reg <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      score_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= finish_en;
      if (load_en) begin
        white_reg <= white_pawns;
        black_reg <= black_pawns;
        cnt_reg   <= '0;
        acc_reg   <= '0;
      end else if (scan_en) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + 7'(SQ_PER_CYCLE);
      end
      if (finish_en) score_reg <= acc_next;
    end
  end

`ifdef PAWN_PST_COUNT_EN
  logic [6:0] white_pop, black_pop;
  logic [6:0] white_cnt_reg, black_cnt_reg, white_count_reg, black_count_reg;

  always_comb begin
    white_pop = '0;
    black_pop = '0;
    for (int i = 0; i < SQ_PER_CYCLE; i++) begin
      white_pop = white_pop + 7'(white_mask[i]);
      black_pop = black_pop + 7'(black_mask[i]);
    end
  end

  // Running counts live alongside the accumulator; the visible copies update only with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      white_cnt_reg   <= '0;
      black_cnt_reg   <= '0;
      white_count_reg <= '0;
      black_count_reg <= '0;
    end else begin
      if (load_en) begin
        white_cnt_reg <= '0;
        black_cnt_reg <= '0;
      end else if (scan_en) begin
        white_cnt_reg <= white_cnt_reg + white_pop;
        black_cnt_reg <= black_cnt_reg + black_pop;
      end
      if (finish_en) begin
        white_count_reg <= white_cnt_reg + white_pop;
        black_count_reg <= black_cnt_reg + black_pop;
      end
    end
  end

  assign white_count = white_count_reg;
  assign black_count = black_count_reg;
`endif

  assign ready = (state_reg == IDLE) || (state_reg == DONE);
  assign busy  = (state_reg == LOAD) || (state_reg == SCAN);
  assign done  = done_reg;
  assign score = score_reg;

endmodule

// File: doc/pawn_pst_accumulator.md
Name: pawn_pst_accumulator

Overview:
- Sequential pawn positional-score stage. It sits directly downstream of the pawn piece-square ROM.
- Consumes the ROM's flat 384-bit table (64 x 6-bit signed entries; entry s at bits [6s+5:6s]) plus the white and black pawn bitboards.
- Produces one signed score: sum of white-pawn table values minus sum of black-pawn table values, with black squares rank-mirrored.
- Scans SQ_PER_CYCLE squares per clock under a start/done handshake, so the full-board adder tree is never built in one cycle.

Parameters:
- SQ_PER_CYCLE, 8, squares summed per scan cycle; legal values 1, 2, 4, 8, 16, 32, 64.
- SCORE_W, 12, width of the signed score output; must be >= 10.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request evaluation; accepted only when ready=1.
- white_pawns  input  64  bit s = white pawn on square s (a1=0, h8=63).
- black_pawns  input  64  same encoding for black.
- pst_flat  input  384  pawn table from the ROM; treated as static.
- ready  output  1  high in IDLE and DONE.
- busy  output  1  high in LOAD and SCAN.
- done  output  1  single-cycle pulse when score becomes valid.
- score  output  SCORE_W  signed (white - black); held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high) sets state=IDLE, ready=1, busy=0, done=0, score=0, accumulator=0, square counter=0.
- Reset asserted mid-scan aborts the scan in the same edge. No done pulse is produced for the aborted job.
- States: IDLE, LOAD, SCAN, DONE.
  - IDLE, start=1 -> LOAD.
  - LOAD: latch both bitboards; clear accumulator and counter -> SCAN.
  - SCAN: each cycle add the slice of squares c..c+SQ_PER_CYCLE-1.
    - While c + SQ_PER_CYCLE < 64: stay in SCAN.
    - Otherwise: register score and pulse done -> DONE.
  - DONE: start=1 -> LOAD (back-to-back); else -> IDLE.
- Slice contribution for square s:
  - (white_latched[s] ? pst[s] : 0) - (black_latched[s] ? pst[s ^ 56] : 0).
  - s ^ 56 flips the rank and keeps the file.
  - Every pst entry is sign-extended to SCORE_W before the add.
- Latency: done is high in the cycle after start is sampled plus 1 + 64/SQ_PER_CYCLE cycles, i.e. 9 cycles for the default.
- score updates in the same edge that raises done.
- start while busy=1 is ignored, and no job is queued. The bitboards may change freely after LOAD.
- Arithmetic never saturates. The bound is |score| <= 8*32 + 8*20 = 416, which fits 10 signed bits.
- Overlapping pawns (the same bit set in both boards) are summed without error checking.

Optional Feature:
- Macro: PAWN_PST_COUNT_EN.
- Defined:
  - Adds outputs white_count[6:0] and black_count[6:0]: popcounts of the latched boards.
  - They are accumulated per slice and valid with done.
  - Reset value is 0; they hold like score.
- Undefined: these ports and their counters are absent. score and timing are identical in both builds.

Decomposition:
- Package pawn_eval_pkg:
  - NUM_SQ=64, PST_W=6, PST_FLAT_W=384.
  - State enum {IDLE, LOAD, SCAN, DONE}.
  - Function mirror_sq(s) = s ^ 56.
  - Function pst_entry(flat, s) returning a signed PST_W slice.
- Sub-module pst_slice_adder: combinational sum of SQ_PER_CYCLE masked, sign-extended entries for one side (mask, base index, pst_flat, mirror flag -> signed partial sum).
- The top instantiates pst_slice_adder twice, once for white and once for black.

Test Plan:
- White pawn on e2 only (bit 12), black empty -> score = -32, done exactly 9 cycles after start.
- White pawn on e7 only (bit 52) -> score = +20; black pawn on e7 only -> mirrored to e2 -> score = +32.
- Start position (white 0x000000000000FF00, black 0x00FF000000000000) -> score = 0. With COUNT_EN: white_count = black_count = 8.
- Start pulsed at cycles 2 and 5 of a scan -> ignored, exactly one done. Start held in DONE -> second job starts immediately with no IDLE cycle.
- Reset asserted at SCAN cycle 4 -> next cycle: IDLE, score=0, done never pulses. A new start then completes normally.
- Sweep SQ_PER_CYCLE in {1, 8, 64} with random boards vs a reference model -> matching score; latency = 1 + 64/SQ_PER_CYCLE (65, 9, 2 cycles after the accepting edge).
